instr_fetch: RTL and testbench

- Front-end fetch stage. Owns the architectural PC and issues instruction requests on the instruction bus.
- Delivers one fetch_data_t per instruction to decode over a valid/stall interface.
- Handles redirects from execute (branch, jal, jalr): discards wrong-path responses and honours bus stability rules.
- Sits between the instruction bus/cache and the decode stage.

---
 rtl/instr_fetch_pkg.sv | 25 ++
 rtl/instr_fetch_skid.sv | 24 ++
 rtl/instr_fetch.sv | 139 +++++++++++++
 tb/tb_instr_fetch.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the fetch front end.
package instr_fetch_pkg;

    localparam logic [63:0] PC_RESET = 64'h0000_0000_8000_0000;
    localparam logic [63:0] PC_STEP  = 64'd4;

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DROP
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] raw_instr;
        logic [63:0] pc;
        logic        en;
    } fetch_data_t;

    // Redirect targets are always word aligned; the low two bits are ignored.
    function automatic logic [63:0] align_pc(input logic [63:0] p);
        return {p[63:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_skid.sv
// One-entry holding buffer for a fetched instruction that decode could not take yet.
module fetch_skid
    import instr_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        drain,
    input  logic        clear,
    input  fetch_data_t load_data,
    output fetch_data_t data
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data <= '0;
        end else if (clear || drain) begin
            data <= '0;
        end else if (load) begin
            data <= load_data;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, issues one instruction request at a time and
// hands returned words to decode, discarding responses made stale by redirects.
module instr_fetch
    import instr_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    output logic        ireq_valid,
    output logic [63:0] ireq_addr,
    input  logic        ireq_addr_ok,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    input  logic        stall,
    output fetch_data_t fetch_out
);

    fetch_state_t state, state_next;
    logic [63:0]  pc, pc_next;
    logic [63:0]  pend_pc, pend_pc_next;
    logic         pend_valid, pend_valid_next;
    fetch_data_t  out_next, skid_data, skid_in;
    logic         skid_load, skid_drain, skid_clear;
    logic [63:0]  redirect_target;
    logic         out_free, addr_hs;

    assign redirect_target = align_pc(redirect_pc);
    assign out_free        = !fetch_out.en || !stall;
    assign ireq_addr       = pc;
    assign addr_hs         = ireq_valid && ireq_addr_ok;
    assign skid_in         = '{raw_instr: iresp_data, pc: pc, en: 1'b1};

    // No new request while a finished instruction is stuck in front of a stalled decode.
    assign ireq_valid = reset && (state == S_REQ) && !(fetch_out.en && stall);

    fetch_skid u_skid (
        .clk       (clk),
        .reset     (reset),
        .load      (skid_load),
        .drain     (skid_drain),
        .clear     (skid_clear),
        .load_data (skid_in),
        .data      (skid_data)
    );

    always_comb begin
        state_next      = state;
        pc_next         = pc;
        pend_valid_next = pend_valid;
        pend_pc_next    = pend_pc;
        out_next        = fetch_out;
        skid_load       = 1'b0;
        skid_drain      = 1'b0;
        skid_clear      = redirect_valid;
        if (fetch_out.en && !stall) out_next.en = 1'b0;
        if (redirect_valid) out_next.en = 1'b0;

        case (state)
            S_REQ: begin
                if (addr_hs) begin
                    if (redirect_valid) begin
                        pc_next         = redirect_target;
                        pend_valid_next = 1'b0;
                        state_next      = S_DROP;
                    end else if (pend_valid) begin
                        pc_next         = pend_pc;
                        pend_valid_next = 1'b0;
                        state_next      = S_DROP;
                    end else begin
                        state_next = S_WAIT;
                    end
                end else if (redirect_valid) begin
                    // An asserted request must keep its address, so park the target.
                    if (ireq_valid) begin
                        pend_valid_next = 1'b1;
                        pend_pc_next    = redirect_target;
                    end else begin
                        pc_next = redirect_target;
                    end
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    pc_next         = redirect_target;
                    pend_valid_next = 1'b0;
                    state_next      = iresp_data_ok ? S_REQ : S_DROP;
                end else if (iresp_data_ok) begin
                    if (pend_valid) begin
                        pc_next         = pend_pc;
                        pend_valid_next = 1'b0;
                        state_next      = S_REQ;
                    end else begin
                        pc_next = pc + PC_STEP;
                        if (out_free) begin
                            out_next   = skid_in;
                            state_next = S_REQ;
                        end else begin
                            skid_load  = 1'b1;
                            state_next = S_HOLD;
                        end
                    end
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    pc_next    = redirect_target;
                    state_next = S_REQ;
                end else if (!stall) begin
                    out_next   = skid_data;
                    skid_drain = 1'b1;
                    state_next = S_REQ;
                end
            end
            S_DROP: begin
                if (redirect_valid) pc_next = redirect_target;
                if (iresp_data_ok) state_next = S_REQ;
            end
            default: state_next = S_REQ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_REQ;
            pc         <= PC_RESET;
            pend_valid <= 1'b0;
            pend_pc    <= '0;
            fetch_out  <= '0;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            pend_valid <= pend_valid_next;
            pend_pc    <= pend_pc_next;
            fetch_out  <= out_next;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed vector table, mid-operation reset, then a
// randomized run against a program-order model of the fetched stream.
module tb_instr_fetch;
    import instr_fetch_pkg::*;

    logic        clk;
    logic        reset;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        ireq_addr_ok;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        stall;
    fetch_data_t fetch_out;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
        logic        redir;
        logic [63:0] rpc;
        logic        stall;
        logic        exp_valid;
        logic [63:0] exp_addr;
        logic        exp_en;
        logic [63:0] exp_pc;
        logic [31:0] exp_instr;
    } vec_t;

    vec_t vecs[$];

    instr_fetch dut (
        .clk            (clk),
        .reset          (reset),
        .ireq_valid     (ireq_valid),
        .ireq_addr      (ireq_addr),
        .ireq_addr_ok   (ireq_addr_ok),
        .iresp_data_ok  (iresp_data_ok),
        .iresp_data     (iresp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .fetch_out      (fetch_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h9E37_79B9 ^ {a[15:0], a[31:16]};
    endfunction

    task automatic check_output(input string name, input logic [63:0] actual,
                                input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic add_vec(input logic ao, input logic dok, input logic [31:0] d,
                           input logic rv, input logic [63:0] rp, input logic st,
                           input logic ev, input logic [63:0] ea, input logic een,
                           input logic [63:0] ep, input logic [31:0] ei);
        vec_t v;
        v.addr_ok = ao;   v.data_ok = dok; v.data = d;
        v.redir   = rv;   v.rpc     = rp;  v.stall = st;
        v.exp_valid = ev; v.exp_addr = ea; v.exp_en = een;
        v.exp_pc  = ep;   v.exp_instr = ei;
        vecs.push_back(v);
    endtask

    task automatic apply_stimulus(input vec_t v);
        @(negedge clk);
        ireq_addr_ok   = v.addr_ok;
        iresp_data_ok  = v.data_ok;
        iresp_data     = v.data;
        redirect_valid = v.redir;
        redirect_pc    = v.rpc;
        stall          = v.stall;
        #1;
    endtask

    task automatic clear_inputs();
        ireq_addr_ok   = 1'b0;
        iresp_data_ok  = 1'b0;
        iresp_data     = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        stall          = 1'b0;
    endtask

    localparam logic [63:0] A  = 64'h0000_0000_8000_0000;
    localparam logic [63:0] R1 = 64'h0000_0000_8000_1000;
    localparam logic [63:0] R2 = 64'h0000_0000_8000_2000;
    localparam logic [63:0] RW = 64'hFFFF_FFFF_FFFF_FFFC;

    // Randomized-run model state
    logic [63:0] exp_pc, out_addr, hold_addr, cur_addr;
    logic        outstanding, hold_req, req_fire, consume, valid_pre;
    int          delivered;

    initial begin
        clear_inputs();
        reset = 1'b0;

        // Directed trace: one row per cycle, outputs observed before the edge.
        add_vec(1,0,32'h0,0,64'h0,0,              1,A,0,64'h0,32'h0);
        add_vec(0,1,32'h1111_1111,0,64'h0,0,      0,A,0,64'h0,32'h0);
        add_vec(0,0,32'h0,0,64'h0,0,              1,A+4,1,A,32'h1111_1111);
        add_vec(0,0,32'h0,1,R1,0,                 1,A+4,0,64'h0,32'h0);
        add_vec(0,0,32'h0,0,64'h0,0,              1,A+4,0,64'h0,32'h0);
        add_vec(0,0,32'h0,0,64'h0,0,              1,A+4,0,64'h0,32'h0);
        add_vec(1,0,32'h0,0,64'h0,0,              1,A+4,0,64'h0,32'h0);
        add_vec(0,1,32'hDEAD_BEEF,0,64'h0,0,      0,R1,0,64'h0,32'h0);
        add_vec(1,0,32'h0,0,64'h0,0,              1,R1,0,64'h0,32'h0);
        add_vec(0,1,32'h0000_0013,1,R2,0,         0,R1,0,64'h0,32'h0);
        add_vec(1,0,32'h0,0,64'h0,0,              1,R2,0,64'h0,32'h0);
        add_vec(0,1,32'h2222_2222,0,64'h0,0,      0,R2,0,64'h0,32'h0);
        add_vec(1,0,32'h0,0,64'h0,0,              1,R2+4,1,R2,32'h2222_2222);
        add_vec(0,1,32'h3333_3333,0,64'h0,1,      0,R2+4,0,64'h0,32'h0);
        add_vec(0,0,32'h0,0,64'h0,1,              0,R2+8,1,R2+4,32'h3333_3333);
        add_vec(0,0,32'h0,0,64'h0,1,              0,R2+8,1,R2+4,32'h3333_3333);
        add_vec(0,0,32'h0,0,64'h0,1,              0,R2+8,1,R2+4,32'h3333_3333);
        add_vec(1,0,32'h0,0,64'h0,0,              1,R2+8,1,R2+4,32'h3333_3333);
        add_vec(0,1,32'h4444_4444,0,64'h0,0,      0,R2+8,0,64'h0,32'h0);
        add_vec(0,0,32'h0,1,64'hFFFF_FFFF_FFFF_FFFF,0, 1,R2+12,1,R2+8,32'h4444_4444);
        add_vec(1,0,32'h0,0,64'h0,0,              1,R2+12,0,64'h0,32'h0);
        add_vec(0,1,32'hCAFE_F00D,0,64'h0,0,      0,RW,0,64'h0,32'h0);
        add_vec(1,0,32'h0,0,64'h0,0,              1,RW,0,64'h0,32'h0);
        add_vec(0,1,32'h5555_5555,0,64'h0,0,      0,RW,0,64'h0,32'h0);
        add_vec(0,0,32'h0,0,64'h0,0,              1,64'h0,1,RW,32'h5555_5555);
        add_vec(1,0,32'h0,0,64'h0,0,              1,64'h0,0,64'h0,32'h0);

        repeat (2) @(negedge clk);
        #1;
        check_output("reset valid", ireq_valid, 0);
        check_output("reset addr", ireq_addr, A);
        check_output("reset fetch_out", fetch_out, 0);

        @(negedge clk);
        reset = 1'b1;

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i]);
            check_output($sformatf("v%0d valid", i), ireq_valid, vecs[i].exp_valid);
            check_output($sformatf("v%0d addr", i), ireq_addr, vecs[i].exp_addr);
            check_output($sformatf("v%0d en", i), fetch_out.en, vecs[i].exp_en);
            if (vecs[i].exp_en) begin
                check_output($sformatf("v%0d pc", i), fetch_out.pc, vecs[i].exp_pc);
                check_output($sformatf("v%0d instr", i), fetch_out.raw_instr, vecs[i].exp_instr);
            end
        end

        // Last row accepted a request to 0x0, so the block now waits for data.
        @(negedge clk);
        clear_inputs();
        #2;
        reset = 1'b0;
        #1;
        check_output("async reset valid", ireq_valid, 0);
        check_output("async reset addr", ireq_addr, A);
        check_output("async reset en", fetch_out.en, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_output("post reset valid", ireq_valid, 1);
        check_output("post reset addr", ireq_addr, A);

        // Randomized run; the bus is reset along with the block.
        @(negedge clk);
        reset = 1'b0;
        clear_inputs();
        exp_pc      = A;
        outstanding = 1'b0;
        hold_req    = 1'b0;
        hold_addr   = '0;
        out_addr    = '0;
        delivered   = 0;
        @(negedge clk);
        reset = 1'b1;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            stall          = ($urandom_range(0, 3) == 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = {$urandom(), $urandom()};
            if ($urandom_range(0, 3) == 0)
                redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
            iresp_data_ok  = outstanding && ($urandom_range(0, 2) == 0);
            iresp_data     = iresp_data_ok ? mem_word(out_addr) : $urandom();
            ireq_addr_ok   = 1'b0;
            #1;
            ireq_addr_ok   = ireq_valid && ($urandom_range(0, 1) == 0);
            #1;
            if (hold_req) begin
                check_output("req held valid", ireq_valid, 1);
                check_output("req held addr", ireq_addr, hold_addr);
            end
            if (outstanding) check_output("one outstanding", ireq_valid, 0);
            valid_pre = ireq_valid;
            req_fire  = ireq_valid && ireq_addr_ok;
            cur_addr  = ireq_addr;
            consume   = fetch_out.en && !stall;
            if (consume) begin
                check_output("stream pc", fetch_out.pc, exp_pc);
                check_output("stream instr", fetch_out.raw_instr, mem_word(exp_pc));
            end
            @(posedge clk);
            if (consume) begin
                exp_pc = exp_pc + 64'd4;
                delivered++;
            end
            if (redirect_valid) exp_pc = {redirect_pc[63:2], 2'b00};
            if (iresp_data_ok) outstanding = 1'b0;
            if (req_fire) begin
                outstanding = 1'b1;
                out_addr    = cur_addr;
            end
            hold_req  = valid_pre && !ireq_addr_ok;
            hold_addr = cur_addr;
        end
        check_output("liveness", 64'(delivered > 100), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
